// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge port of the memory-access stage.
// The stage drives the request side; the memory drives ack and read data.
interface mem_access_stage_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [63:0]       dmem_wdata;
    logic [7:0]        dmem_wstrb;
    logic              dmem_ack;
    logic [63:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory stage: issues load/store requests, aligns and extends load data, emits one writeback beat.
// Optional macro MEM_ACCESS_TIMEOUT_EN adds a WAIT-state timeout fault after TIMEOUT_CYCLES.
module mem_access_stage #(
    parameter int unsigned ADDR_W         = 64,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_in,
    input  logic [63:0]         alu_result,
    input  logic [63:0]         rs2_data,
    input  logic [2:0]          funct3,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [4:0]          rd_in,
    input  logic                reg_write_in,
    output logic                stall_out,
    mem_access_stage_if.master  dmem,
    output logic                valid_out,
    output logic [63:0]         wb_data,
    output logic [4:0]          rd_out,
    output logic                reg_write_out,
    output logic                fault_out,
    output logic [1:0]          fault_code
);

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;
    localparam logic [1:0] FC_ILLEGAL  = 2'b11;

    state_e            state_q, state_d;
    logic              req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [7:0]        wstrb_q, wstrb_d;
    logic [2:0]        addr_lo_q, addr_lo_d, f3_q, f3_d;
    logic [4:0]        rd_q, rd_d, rd_out_q, rd_out_d;
    logic              regw_q, regw_d;
    logic              valid_out_q, valid_out_d, reg_write_out_q, reg_write_out_d;
    logic              fault_q, fault_d;
    logic [1:0]        fault_code_q, fault_code_d;
    logic [63:0]       wb_data_q, wb_data_d;

    logic              mem_op_c, is_store_c, illegal_c, misalign_c, legal_c;
    logic [7:0]        strb_c;
    logic [63:0]       load_sh_c, load_val_c;
    logic              timeout_c;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout_c = 1'b0;
`endif

    // Access decode: a load wins when both mem_read and mem_write are set.
    always_comb begin
        mem_op_c   = mem_read | mem_write;
        is_store_c = mem_write & ~mem_read;
        illegal_c  = mem_read ? (funct3 == 3'b111) : funct3[2];
        case (funct3[1:0])
            2'b01:   misalign_c = alu_result[0];
            2'b10:   misalign_c = |alu_result[1:0];
            2'b11:   misalign_c = |alu_result[2:0];
            default: misalign_c = 1'b0;
        endcase
        legal_c = mem_op_c & ~illegal_c & ~misalign_c;
        case (funct3[1:0])
            2'b00:   strb_c = 8'h01 << alu_result[2:0];
            2'b01:   strb_c = 8'h03 << alu_result[2:0];
            2'b10:   strb_c = 8'h0F << alu_result[2:0];
            default: strb_c = 8'hFF;
        endcase
    end

    // Load lane alignment and sign/zero extension from the captured access.
    always_comb begin
        load_sh_c = dmem.dmem_rdata >> {addr_lo_q, 3'b000};
        case (f3_q)
            3'b000:  load_val_c = {{56{load_sh_c[7]}},  load_sh_c[7:0]};
            3'b001:  load_val_c = {{48{load_sh_c[15]}}, load_sh_c[15:0]};
            3'b010:  load_val_c = {{32{load_sh_c[31]}}, load_sh_c[31:0]};
            3'b011:  load_val_c = load_sh_c;
            3'b100:  load_val_c = {56'b0, load_sh_c[7:0]};
            3'b101:  load_val_c = {48'b0, load_sh_c[15:0]};
            3'b110:  load_val_c = {32'b0, load_sh_c[31:0]};
            default: load_val_c = 64'b0;
        endcase
    end

    assign stall_out = ((state_q == S_IDLE) & valid_in & legal_c) | (state_q == S_WAIT);

    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        we_d            = we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        wstrb_d         = wstrb_q;
        addr_lo_d       = addr_lo_q;
        f3_d            = f3_q;
        rd_d            = rd_q;
        regw_d          = regw_q;
        valid_out_d     = 1'b0;
        wb_data_d       = 64'b0;
        rd_out_d        = 5'b0;
        reg_write_out_d = 1'b0;
        fault_d         = 1'b0;
        fault_code_d    = 2'b00;
`ifdef MEM_ACCESS_TIMEOUT_EN
        cnt_d           = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    if (!mem_op_c) begin
                        valid_out_d     = 1'b1;
                        wb_data_d       = alu_result;
                        rd_out_d        = rd_in;
                        reg_write_out_d = reg_write_in;
                    end else if (illegal_c || misalign_c) begin
                        valid_out_d  = 1'b1;
                        rd_out_d     = rd_in;
                        fault_d      = 1'b1;
                        fault_code_d = illegal_c ? FC_ILLEGAL : FC_MISALIGN;
                    end else begin
                        state_d   = S_WAIT;
                        req_d     = 1'b1;
                        we_d      = is_store_c;
                        addr_d    = ADDR_W'({alu_result[63:3], 3'b000});
                        wdata_d   = rs2_data << {alu_result[2:0], 3'b000};
                        wstrb_d   = strb_c;
                        addr_lo_d = alu_result[2:0];
                        f3_d      = funct3;
                        rd_d      = rd_in;
                        regw_d    = reg_write_in;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        cnt_d     = '0;
`endif
                    end
                end
            end
            S_WAIT: begin
                // An ack in the timeout cycle completes the access normally.
                if (dmem.dmem_ack) begin
                    state_d     = S_IDLE;
                    req_d       = 1'b0;
                    valid_out_d = 1'b1;
                    rd_out_d    = rd_q;
                    if (!we_q) begin
                        wb_data_d       = load_val_c;
                        reg_write_out_d = regw_q;
                    end
                end else if (timeout_c) begin
                    state_d      = S_IDLE;
                    req_d        = 1'b0;
                    valid_out_d  = 1'b1;
                    rd_out_d     = rd_q;
                    fault_d      = 1'b1;
                    fault_code_d = FC_TIMEOUT;
                end else begin
`ifdef MEM_ACCESS_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            req_q           <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= 64'b0;
            wstrb_q         <= 8'b0;
            addr_lo_q       <= 3'b0;
            f3_q            <= 3'b0;
            rd_q            <= 5'b0;
            regw_q          <= 1'b0;
            valid_out_q     <= 1'b0;
            wb_data_q       <= 64'b0;
            rd_out_q        <= 5'b0;
            reg_write_out_q <= 1'b0;
            fault_q         <= 1'b0;
            fault_code_q    <= 2'b00;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            req_q           <= req_d;
            we_q            <= we_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            wstrb_q         <= wstrb_d;
            addr_lo_q       <= addr_lo_d;
            f3_q            <= f3_d;
            rd_q            <= rd_d;
            regw_q          <= regw_d;
            valid_out_q     <= valid_out_d;
            wb_data_q       <= wb_data_d;
            rd_out_q        <= rd_out_d;
            reg_write_out_q <= reg_write_out_d;
            fault_q         <= fault_d;
            fault_code_q    <= fault_code_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q           <= cnt_d;
`endif
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_wstrb = wstrb_q;
    assign valid_out       = valid_out_q;
    assign wb_data         = wb_data_q;
    assign rd_out          = rd_out_q;
    assign reg_write_out   = reg_write_out_q;
    assign fault_out       = fault_q;
    assign fault_code      = fault_code_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: single-beat vector table plus multi-cycle sequences.
module tb_mem_access_stage;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int unsigned TO_CYC = 4;
`else
    localparam int unsigned TO_CYC = 256;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [63:0] alu_result, rs2_data;
    logic [2:0]  funct3;
    logic        mem_read, mem_write;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        stall_out;
    logic        valid_out;
    logic [63:0] wb_data;
    logic [4:0]  rd_out;
    logic        reg_write_out, fault_out;
    logic [1:0]  fault_code;

    int checks = 0;
    int errors = 0;
    int stall_cnt;

    mem_access_stage_if #(.ADDR_W(64)) dif ();

    mem_access_stage #(.ADDR_W(64), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_in      (valid_in),
        .alu_result    (alu_result),
        .rs2_data      (rs2_data),
        .funct3        (funct3),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .rd_in         (rd_in),
        .reg_write_in  (reg_write_in),
        .stall_out     (stall_out),
        .dmem          (dif.master),
        .valid_out     (valid_out),
        .wb_data       (wb_data),
        .rd_out        (rd_out),
        .reg_write_out (reg_write_out),
        .fault_out     (fault_out),
        .fault_code    (fault_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vin;
        logic [63:0] alu;
        logic [2:0]  f3;
        logic        mr;
        logic        mw;
        logic [4:0]  rd;
        logic        rw;
        logic        e_valid;
        logic [63:0] e_wb;
        logic        e_rw;
        logic        e_fault;
        logic [1:0]  e_code;
        logic        chk_rd;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] d,
                         input logic [2:0] f, input logic mr, input logic mw,
                         input logic [4:0] rd, input logic rw);
        valid_in     = v;
        alu_result   = a;
        rs2_data     = d;
        funct3       = f;
        mem_read     = mr;
        mem_write    = mw;
        rd_in        = rd;
        reg_write_in = rw;
    endtask

    task automatic idle();
        drive(1'b0, 64'h0, 64'h0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        dif.dmem_ack   = 1'b0;
        dif.dmem_rdata = 64'h0;

        vecs[0] = '{1'b1, 64'h1234, 3'b000, 1'b0, 1'b0, 5'd5,  1'b1, 1'b1, 64'h1234, 1'b1, 1'b0, 2'b00, 1'b1};
        vecs[1] = '{1'b0, 64'h5555, 3'b000, 1'b0, 1'b0, 5'd6,  1'b1, 1'b0, 64'h0,    1'b0, 1'b0, 2'b00, 1'b0};
        vecs[2] = '{1'b1, 64'h3002, 3'b010, 1'b1, 1'b0, 5'd4,  1'b1, 1'b1, 64'h0,    1'b0, 1'b1, 2'b01, 1'b0};
        vecs[3] = '{1'b1, 64'h1000, 3'b100, 1'b0, 1'b1, 5'd2,  1'b0, 1'b1, 64'h0,    1'b0, 1'b1, 2'b11, 1'b0};
        vecs[4] = '{1'b1, 64'h1001, 3'b111, 1'b1, 1'b0, 5'd3,  1'b1, 1'b1, 64'h0,    1'b0, 1'b1, 2'b11, 1'b0};
        vecs[5] = '{1'b1, 64'h2004, 3'b011, 1'b0, 1'b1, 5'd1,  1'b0, 1'b1, 64'h0,    1'b0, 1'b1, 2'b01, 1'b0};
        vecs[6] = '{1'b1, 64'h0005, 3'b001, 1'b1, 1'b1, 5'd8,  1'b1, 1'b1, 64'h0,    1'b0, 1'b1, 2'b01, 1'b0};
        vecs[7] = '{1'b1, 64'hDEAD, 3'b000, 1'b0, 1'b0, 5'd31, 1'b0, 1'b1, 64'hDEAD, 1'b0, 1'b0, 2'b00, 1'b1};

        #12;
        chk("rst valid_out", 64'(valid_out), 64'd0);
        chk("rst dmem_req", 64'(dif.dmem_req), 64'd0);
        chk("rst fault_out", 64'(fault_out), 64'd0);
        chk("rst stall_out", 64'(stall_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-beat vectors: pass-through, faults, idle slot
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(vecs[i].vin, vecs[i].alu, 64'hFFFF_0000_1111_2222, vecs[i].f3,
                  vecs[i].mr, vecs[i].mw, vecs[i].rd, vecs[i].rw);
            #1;
            chk($sformatf("v%0d stall", i), 64'(stall_out), 64'd0);
            tick();
            chk($sformatf("v%0d valid", i), 64'(valid_out), 64'(vecs[i].e_valid));
            chk($sformatf("v%0d req", i), 64'(dif.dmem_req), 64'd0);
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d wb", i), wb_data, vecs[i].e_wb);
                chk($sformatf("v%0d rw", i), 64'(reg_write_out), 64'(vecs[i].e_rw));
                chk($sformatf("v%0d fault", i), 64'(fault_out), 64'(vecs[i].e_fault));
                chk($sformatf("v%0d code", i), 64'(fault_code), 64'(vecs[i].e_code));
                if (vecs[i].chk_rd) chk($sformatf("v%0d rd", i), 64'(rd_out), 64'(vecs[i].rd));
            end
        end

        // LB at 0x1003, ack on third WAIT cycle, new op waits behind it
        @(negedge clk);
        drive(1'b1, 64'h1003, 64'h0, 3'b000, 1'b1, 1'b0, 5'd7, 1'b1);
        #1;
        stall_cnt = int'(stall_out);
        tick();
        chk("lb req", 64'(dif.dmem_req), 64'd1);
        chk("lb we", 64'(dif.dmem_we), 64'd0);
        chk("lb addr", dif.dmem_addr, 64'h1000);
        chk("lb wstrb", 64'(dif.dmem_wstrb), 64'h08);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) drive(1'b1, 64'hBAD, 64'h0, 3'b000, 1'b0, 1'b0, 5'd10, 1'b1);
            if (k == 3) begin
                dif.dmem_ack   = 1'b1;
                dif.dmem_rdata = 64'h00000000_80000000;
            end
            #1;
            stall_cnt += int'(stall_out);
            if (k < 3) chk("lb no early valid", 64'(valid_out), 64'd0);
            tick();
        end
        chk("lb valid", 64'(valid_out), 64'd1);
        chk("lb wb", wb_data, 64'hFFFFFFFF_FFFFFF80);
        chk("lb rd", 64'(rd_out), 64'd7);
        chk("lb rw", 64'(reg_write_out), 64'd1);
        chk("lb req drop", 64'(dif.dmem_req), 64'd0);
        chk("lb stall at wb", 64'(stall_out), 64'd0);
        chk("lb stall cycles", 64'(stall_cnt), 64'd4);
        @(negedge clk);
        dif.dmem_ack = 1'b0;
        tick();
        chk("follow valid", 64'(valid_out), 64'd1);
        chk("follow wb", wb_data, 64'hBAD);
        chk("follow rd", 64'(rd_out), 64'd10);

        // SH at 0x2006, ack on first WAIT cycle
        @(negedge clk);
        drive(1'b1, 64'h2006, 64'hABCD, 3'b001, 1'b0, 1'b1, 5'd3, 1'b1);
        tick();
        chk("sh we", 64'(dif.dmem_we), 64'd1);
        chk("sh addr", dif.dmem_addr, 64'h2000);
        chk("sh wstrb", 64'(dif.dmem_wstrb), 64'hC0);
        chk("sh wdata", dif.dmem_wdata, 64'hABCD0000_00000000);
        @(negedge clk);
        idle();
        dif.dmem_ack   = 1'b1;
        dif.dmem_rdata = 64'h12345678_9ABCDEF0;
        tick();
        chk("sh valid", 64'(valid_out), 64'd1);
        chk("sh rw", 64'(reg_write_out), 64'd0);
        chk("sh wb", wb_data, 64'h0);
        chk("sh fault", 64'(fault_out), 64'd0);

        // Ack while idle is ignored
        @(negedge clk);
        dif.dmem_ack = 1'b1;
        tick();
        chk("idle ack valid", 64'(valid_out), 64'd0);
        chk("idle ack req", 64'(dif.dmem_req), 64'd0);

        // LWU at 0x4004: zero-extended upper word
        @(negedge clk);
        dif.dmem_ack = 1'b0;
        drive(1'b1, 64'h4004, 64'h0, 3'b110, 1'b1, 1'b0, 5'd12, 1'b1);
        tick();
        chk("lwu wstrb", 64'(dif.dmem_wstrb), 64'hF0);
        @(negedge clk);
        idle();
        dif.dmem_ack   = 1'b1;
        dif.dmem_rdata = 64'h81223344_55667788;
        tick();
        chk("lwu wb", wb_data, 64'h00000000_81223344);

        // Reset while waiting drops the request at once
        @(negedge clk);
        dif.dmem_ack = 1'b0;
        drive(1'b1, 64'h5000, 64'h0, 3'b011, 1'b1, 1'b0, 5'd9, 1'b1);
        tick();
        chk("pre-rst req", 64'(dif.dmem_req), 64'd1);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst req drop", 64'(dif.dmem_req), 64'd0);
        chk("rst stall", 64'(stall_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dif.dmem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post-rst valid", 64'(valid_out), 64'd0);
        end
        @(negedge clk);
        dif.dmem_ack = 1'b0;

`ifdef MEM_ACCESS_TIMEOUT_EN
        // No ack: fault after TIMEOUT_CYCLES WAIT cycles
        drive(1'b1, 64'h6000, 64'h0, 3'b011, 1'b1, 1'b0, 5'd11, 1'b1);
        tick();
        idle();
        for (int k = 1; k < 4; k++) begin
            chk("to req held", 64'(dif.dmem_req), 64'd1);
            tick();
        end
        chk("to req held", 64'(dif.dmem_req), 64'd1);
        tick();
        chk("to req drop", 64'(dif.dmem_req), 64'd0);
        chk("to valid", 64'(valid_out), 64'd1);
        chk("to fault", 64'(fault_out), 64'd1);
        chk("to code", 64'(fault_code), 64'd2);
        chk("to rw", 64'(reg_write_out), 64'd0);
        // Ack in the timeout cycle wins
        @(negedge clk);
        drive(1'b1, 64'h6000, 64'h0, 3'b011, 1'b1, 1'b0, 5'd11, 1'b1);
        tick();
        idle();
        for (int k = 1; k < 4; k++) tick();
        @(negedge clk);
        dif.dmem_ack   = 1'b1;
        dif.dmem_rdata = 64'h0000_0000_0000_0042;
        tick();
        chk("to ack valid", 64'(valid_out), 64'd1);
        chk("to ack fault", 64'(fault_out), 64'd0);
        chk("to ack wb", wb_data, 64'h42);
        @(negedge clk);
        dif.dmem_ack = 1'b0;
`else
        // Without the timeout, WAIT holds well past 256 cycles
        drive(1'b1, 64'h6000, 64'h0, 3'b011, 1'b1, 1'b0, 5'd11, 1'b1);
        tick();
        idle();
        stall_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            stall_cnt += int'(valid_out);
        end
        chk("hold req", 64'(dif.dmem_req), 64'd1);
        chk("hold no valid", 64'(stall_cnt), 64'd0);
        chk("hold stall", 64'(stall_out), 64'd1);
        @(negedge clk);
        dif.dmem_ack   = 1'b1;
        dif.dmem_rdata = 64'h0000_0000_0000_0042;
        tick();
        chk("hold ack fault", 64'(fault_out), 64'd0);
        chk("hold ack wb", wb_data, 64'h42);
        @(negedge clk);
        dif.dmem_ack = 1'b0;
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 64-bit pipeline, downstream of the execute stage.
- Takes the ALU result as a load/store address or pass-through value, and rs2 data as store data.
- Runs a request/acknowledge transaction on the data-memory port, and aligns plus sign/zero-extends load data.
- Presents one registered writeback beat to the MEM/WB register and stalls upstream while a memory access is outstanding.

Parameters:
- ADDR_W, 64, address width; dmem_addr width.
- TIMEOUT_CYCLES, 256, cycles in WAIT without dmem_ack before a timeout fault. Used only with MEM_ACCESS_TIMEOUT_EN.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- valid_in  input  1  EX/MEM slot holds a valid instruction
- alu_result  input  64  address for load/store; writeback value otherwise
- rs2_data  input  64  store data
- funct3  input  3  access size/sign
- mem_read  input  1  load
- mem_write  input  1  store
- rd_in  input  5  destination register
- reg_write_in  input  1  instruction writes rd
- stall_out  output  1  upstream must hold EX/MEM contents
- dmem_req  output  1  memory request
- dmem_we  output  1  1=write
- dmem_addr  output  ADDR_W  doubleword-aligned address {addr[63:3],3'b0}
- dmem_wdata  output  64  lane-shifted store data
- dmem_wstrb  output  8  byte enables
- dmem_ack  input  1  request accepted/completed; dmem_rdata valid same cycle
- dmem_rdata  input  64  read doubleword
- valid_out  output  1  writeback beat, one cycle per instruction
- wb_data  output  64  result to write back
- rd_out  output  5  destination register
- reg_write_out  output  1  write enable to register file
- fault_out  output  1  instruction faulted
- fault_code  output  2  01 misaligned, 10 timeout, 11 illegal funct3

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - All outputs are 0; dmem_req drops immediately, including mid-transaction.
  - The aborted access produces no valid_out.
- States: IDLE, WAIT.
- IDLE, valid_in=0: valid_out=0 next cycle.
- IDLE, valid_in=1, no memory op:
  - Next cycle: valid_out=1, wb_data=alu_result, rd_out=rd_in, reg_write_out=reg_write_in.
  - Latency 1; stall_out=0.
- mem_read and mem_write both set: treated as load; mem_write ignored.
- Legality checks (in IDLE with a memory op):
  - Loads: funct3=111 is illegal.
  - Stores: funct3[2]=1 is illegal.
  - Misaligned: half with a[0]≠0, word with a[1:0]≠0, double with a[2:0]≠0.
- Illegal or misaligned: no request issued. Next cycle valid_out=1, fault_out=1 with the matching code, reg_write_out=0, wb_data=0. Illegal takes priority over misaligned.
- Legal access:
  - Capture address, data, funct3, rd and reg_write internally.
  - Go to WAIT, registering dmem_req=1 plus dmem_we, dmem_addr, dmem_wstrb and dmem_wdata.
  - Strobes: byte 1<<a[2:0]; half 3<<a[2:0]; word 0xF<<a[2:0]; double 0xFF.
  - dmem_wdata = rs2_data << (8*a[2:0]).
- stall_out is combinational: 1 when (IDLE and valid_in and legal memory op) or state==WAIT.
- WAIT:
  - dmem_req and all request fields stay stable until dmem_ack is sampled 1.
  - On the ack edge: dmem_req goes to 0, state returns to IDLE, and valid_out=1 for one cycle. Memory-op latency is 1 + cycles to ack.
  - Stall timing: stall_out=0 during the cycle in which valid_out=1. A new instruction is accepted in IDLE the same cycle.
- Load data:
  - sh = dmem_rdata >> (8*a[2:0]).
  - 000 sign-extend sh[7:0]; 001 sign-extend [15:0]; 010 sign-extend [31:0]; 011 sh.
  - 100 / 101 / 110 zero-extend [7:0] / [15:0] / [31:0].
  - reg_write_out=captured reg_write.
- Stores: valid_out=1, reg_write_out=0, wb_data=0.
- dmem_ack outside WAIT is ignored. valid_in changes during WAIT are ignored.

Optional Feature:
- MEM_ACCESS_TIMEOUT_EN defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without ack: dmem_req drops and state returns to IDLE.
  - Next cycle: valid_out=1, fault_out=1, fault_code=10, reg_write_out=0.
  - An ack in the same cycle as the timeout wins, with no fault.
- Undefined: no counter; WAIT is held indefinitely.

Test Plan:
- Non-memory op: alu_result=0x1234, rd_in=5, reg_write_in=1 -> next cycle valid_out=1, wb_data=0x1234, rd_out=5, stall_out never 1.
- LB at 0x1003, ack after 3 cycles with rdata=0x00000000_80000000 -> dmem_addr=0x1000, wstrb=0x08, stall_out=1 for 4 cycles, wb_data=0xFFFFFFFF_FFFFFF80.
- SH at 0x2006, rs2=0xABCD -> dmem_we=1, wstrb=0xC0, wdata=0xABCD0000_00000000, valid_out with reg_write_out=0.
- LW at 0x3002 -> no dmem_req, fault_out=1, fault_code=01. Store with funct3=100 -> fault_code=11.
- rst_n low while in WAIT -> dmem_req=0 immediately, no valid_out after release.
- With MEM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> dmem_req drops after 4 WAIT cycles, fault_code=10.
